exe_forward_alu: RTL and testbench
==================================

# exe_forward_alu

Execute-stage datapath of the 5-stage pipeline. Resolves operand forwarding for both ALU operands and the store-data value through three 3-way selectors. Computes the ALU operation selected by EXE_CMD and registers the ALU result and the forwarded store value into the EXE/MEM boundary.

## Interface
Parameters:
- WORD_LEN, 32: datapath width.
- FORW_SEL_LEN, 2: forwarding-select width.
- EXE_CMD_LEN, 4: ALU command width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- EXE_CMD  in  EXE_CMD_LEN  ALU operation code.
- val1_sel  in  FORW_SEL_LEN  forwarding select for operand 1.
- val2_sel  in  FORW_SEL_LEN  forwarding select for operand 2.
- ST_val_sel  in  FORW_SEL_LEN  forwarding select for store data.
- val1  in  WORD_LEN  register-file operand 1.
- val2  in  WORD_LEN  register-file or immediate operand 2.
- ALU_res_MEM  in  WORD_LEN  ALU result currently in the MEM stage.
- result_WB  in  WORD_LEN  write-back value currently in the WB stage.
- ST_value_in  in  WORD_LEN  store data from the register file.
- SLLAmount  in  8  shift amount, unsigned.
- ALUResult  out  WORD_LEN  registered ALU result.
- ST_value_out  out  WORD_LEN  registered forwarded store data.

## Operation
Forwarding selector, identical for all three paths:
- sel=00 → own input (val1, val2 or ST_value_in).
- sel=01 → ALU_res_MEM.
- sel=10 → result_WB.
- sel=11 → own input, same as 00.

The ALU works on the forwarded operands A and B. All arithmetic is modulo 2^32; there is no overflow or carry output.
- 0000 ADD: A+B.
- 0010 SUB: A−B.
- 0100 AND: A&B.
- 0101 OR: A|B.
- 0110 NOR: ~(A|B).
- 0111 XOR: A^B.
- 1000 SLL: A << SLLAmount.
- 1001 SRA: A >>> SLLAmount, arithmetic (sign fill).
- 1010 SRL: A >> SLLAmount, logical (zero fill).
- 1011 SLT: 1 if signed A < signed B, else 0.
- 1111 NOP, and every other code: result 0.

Shift rules:
- SLLAmount uses all 8 bits, unsigned.
- Amount 0 passes A unchanged.
- Amount ≥32: SLL and SRL give 0; SRA gives all bits equal to A[31].

The store path does not pass through the ALU.

## Timing
- The forwarding muxes and ALU are combinational within the cycle.
- ALUResult and ST_value_out are registered: inputs sampled at edge N appear at the outputs after edge N, so latency is 1 cycle.
- Throughput is 1 operation per cycle; there is no stall or handshake.
- Reset value: ALUResult=0 and ST_value_out=0 while rst is high at a clock edge.
- rst is checked synchronously and overrides all inputs in the same cycle.
- Asserting rst mid-stream discards the operation sampled on that edge; the first valid result appears one edge after rst deasserts.
- All three selectors may pick the same source in the same cycle; the paths are independent.

## Test plan
- Reset: rst=1 for 2 cycles with nonzero inputs → ALUResult=0 and ST_value_out=0; deassert with ADD, val1=5, val2=7, all sel=00 → ALUResult=12 after the next edge.
- Forwarding: SUB with val1=100, val2=1, ALU_res_MEM=50, result_WB=20.
  - val1_sel=01, val2_sel=10 → 30.
  - val1_sel=11, val2_sel=00 → 99.
  - ST_val_sel=01/10/00 with ST_value_in=0xAB → 50 / 20 / 0xAB.
- Logic: A=0xF0F0F0F0, B=0xFF00FF00.
  - AND → 0xF000F000.
  - OR → 0xFFF0FFF0.
  - XOR → 0x0FF00FF0.
  - NOR → 0x000F000F.
- Shifts, A=0x80000001:
  - SLL by 4 → 0x00000010.
  - SRL by 4 → 0x08000000.
  - SRA by 4 → 0xF8000000.
  - SRA by 40 → 0xFFFFFFFF; SRL by 40 → 0.
  - SLL by 0 → 0x80000001.
- Arithmetic edges:
  - ADD 0xFFFFFFFF+1 → 0.
  - SUB 0−1 → 0xFFFFFFFF.
  - SLT −1 vs 1 → 1; SLT 1 vs −1 → 0.
  - NOP or undefined code 0x3 → 0.
- Back-to-back: ADD, SUB and XOR on consecutive cycles each produce the correct value exactly one edge after their inputs, with no bubbles.

Source files
------------

// File: rtl/exe_forward_alu.sv
// -----------------------------------------------------------------------------
// exe_forward_alu -- execute stage of the 5-stage pipeline.
//
// Resolves forwarding for ALU operand 1, ALU operand 2 and the store data.
// Each path has its own 3-way selector. The stage computes the ALU operation
// chosen by EXE_CMD on the forwarded operands. The ALU result and the
// forwarded store value are registered into the EXE/MEM boundary, so the
// latency is one cycle and one operation is accepted every cycle.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset (clears both outputs)
//   EXE_CMD       in   ALU operation code
//   val1_sel      in   forwarding select, operand 1 (00/11 own, 01 MEM, 10 WB)
//   val2_sel      in   forwarding select, operand 2
//   ST_val_sel    in   forwarding select, store data
//   val1          in   register-file operand 1
//   val2          in   register-file / immediate operand 2
//   ALU_res_MEM   in   ALU result currently held in the MEM stage
//   result_WB     in   write-back value currently in the WB stage
//   ST_value_in   in   store data from the register file
//   SLLAmount     in   unsigned 8-bit shift amount
//   ALUResult     out  registered ALU result
//   ST_value_out  out  registered forwarded store data
// -----------------------------------------------------------------------------

// One forwarding selector. The three paths are identical, so this module is
// instantiated once per path.
module exe_forward_mux #(
    parameter int WORD_LEN     = 32,
    parameter int FORW_SEL_LEN = 2
) (
    input  logic [FORW_SEL_LEN-1:0] sel_i,
    input  logic [WORD_LEN-1:0]     own_i,
    input  logic [WORD_LEN-1:0]     mem_i,
    input  logic [WORD_LEN-1:0]     wb_i,
    output logic [WORD_LEN-1:0]     val_o
);
    localparam logic [FORW_SEL_LEN-1:0] SEL_MEM = FORW_SEL_LEN'(2'b01);
    localparam logic [FORW_SEL_LEN-1:0] SEL_WB  = FORW_SEL_LEN'(2'b10);

    // Code 11 is unused by the hazard unit and falls back to the own input.
    always_comb begin
        val_o = own_i;
        if (sel_i == SEL_MEM) begin
            val_o = mem_i;
        end else if (sel_i == SEL_WB) begin
            val_o = wb_i;
        end
    end
endmodule

module exe_forward_alu #(
    parameter int WORD_LEN     = 32,
    parameter int FORW_SEL_LEN = 2,
    parameter int EXE_CMD_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [EXE_CMD_LEN-1:0]  EXE_CMD,
    input  logic [FORW_SEL_LEN-1:0] val1_sel,
    input  logic [FORW_SEL_LEN-1:0] val2_sel,
    input  logic [FORW_SEL_LEN-1:0] ST_val_sel,
    input  logic [WORD_LEN-1:0]     val1,
    input  logic [WORD_LEN-1:0]     val2,
    input  logic [WORD_LEN-1:0]     ALU_res_MEM,
    input  logic [WORD_LEN-1:0]     result_WB,
    input  logic [WORD_LEN-1:0]     ST_value_in,
    input  logic [7:0]              SLLAmount,
    output logic [WORD_LEN-1:0]     ALUResult,
    output logic [WORD_LEN-1:0]     ST_value_out
);
    // Path indices into the packed selector arrays.
    localparam int NUM_PATHS = 3;
    localparam int P_A  = 0;
    localparam int P_B  = 1;
    localparam int P_ST = 2;

    localparam logic [EXE_CMD_LEN-1:0] CMD_ADD = EXE_CMD_LEN'(4'b0000);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SUB = EXE_CMD_LEN'(4'b0010);
    localparam logic [EXE_CMD_LEN-1:0] CMD_AND = EXE_CMD_LEN'(4'b0100);
    localparam logic [EXE_CMD_LEN-1:0] CMD_OR  = EXE_CMD_LEN'(4'b0101);
    localparam logic [EXE_CMD_LEN-1:0] CMD_NOR = EXE_CMD_LEN'(4'b0110);
    localparam logic [EXE_CMD_LEN-1:0] CMD_XOR = EXE_CMD_LEN'(4'b0111);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SLL = EXE_CMD_LEN'(4'b1000);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SRA = EXE_CMD_LEN'(4'b1001);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SRL = EXE_CMD_LEN'(4'b1010);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SLT = EXE_CMD_LEN'(4'b1011);

    // ---------------------------------------------------------------------
    // Forwarding: one selector instance per path
    // ---------------------------------------------------------------------
    logic [NUM_PATHS-1:0][FORW_SEL_LEN-1:0] path_sel;
    logic [NUM_PATHS-1:0][WORD_LEN-1:0]     path_own;
    logic [NUM_PATHS-1:0][WORD_LEN-1:0]     path_fwd;

    assign path_sel[P_A]  = val1_sel;
    assign path_sel[P_B]  = val2_sel;
    assign path_sel[P_ST] = ST_val_sel;
    assign path_own[P_A]  = val1;
    assign path_own[P_B]  = val2;
    assign path_own[P_ST] = ST_value_in;

    for (genvar p = 0; p < NUM_PATHS; p++) begin : g_fwd
        exe_forward_mux #(
            .WORD_LEN     (WORD_LEN),
            .FORW_SEL_LEN (FORW_SEL_LEN)
        ) u_mux (
            .sel_i (path_sel[p]),
            .own_i (path_own[p]),
            .mem_i (ALU_res_MEM),
            .wb_i  (result_WB),
            .val_o (path_fwd[p])
        );
    end

    logic [WORD_LEN-1:0] op_a;
    logic [WORD_LEN-1:0] op_b;
    assign op_a = path_fwd[P_A];
    assign op_b = path_fwd[P_B];

    // ---------------------------------------------------------------------
    // Shifter
    // ---------------------------------------------------------------------
    // The amount is a full 8-bit unsigned value. Amounts of WORD_LEN and
    // above are saturated explicitly so the result never depends on how
    // a tool treats an oversized shift.
    logic                sh_big;
    logic [WORD_LEN-1:0] sll_res;
    logic [WORD_LEN-1:0] srl_res;
    logic [WORD_LEN-1:0] sra_res;

    assign sh_big = (int'(SLLAmount) >= WORD_LEN);

    always_comb begin
        sll_res = '0;
        srl_res = '0;
        sra_res = {WORD_LEN{op_a[WORD_LEN-1]}};
        if (!sh_big) begin
            sll_res = op_a << SLLAmount;
            srl_res = op_a >> SLLAmount;
            sra_res = WORD_LEN'($signed(op_a) >>> SLLAmount);
        end
    end

    // ---------------------------------------------------------------------
    // ALU
    // ---------------------------------------------------------------------
    logic                slt_bit;
    logic [WORD_LEN-1:0] alu_res;

    assign slt_bit = ($signed(op_a) < $signed(op_b));

    // NOP and every undefined code produce zero.
    always_comb begin
        alu_res = '0;
        case (EXE_CMD)
            CMD_ADD: alu_res = op_a + op_b;
            CMD_SUB: alu_res = op_a - op_b;
            CMD_AND: alu_res = op_a & op_b;
            CMD_OR:  alu_res = op_a | op_b;
            CMD_NOR: alu_res = ~(op_a | op_b);
            CMD_XOR: alu_res = op_a ^ op_b;
            CMD_SLL: alu_res = sll_res;
            CMD_SRA: alu_res = sra_res;
            CMD_SRL: alu_res = srl_res;
            CMD_SLT: alu_res = {{(WORD_LEN-1){1'b0}}, slt_bit};
            default: alu_res = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // EXE/MEM boundary registers
    // ---------------------------------------------------------------------
    logic [WORD_LEN-1:0] alu_q, alu_d;
    logic [WORD_LEN-1:0] st_q,  st_d;

    // The store data bypasses the ALU. It only passes through its forwarding
    // selector.
    assign alu_d = alu_res;
    assign st_d  = path_fwd[P_ST];

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q <= '0;
            st_q  <= '0;
        end else begin
            alu_q <= alu_d;
            st_q  <= st_d;
        end
    end

    assign ALUResult    = alu_q;
    assign ST_value_out = st_q;
endmodule

// File: tb/tb_exe_forward_alu.sv
// -----------------------------------------------------------------------------
// Directed testbench for exe_forward_alu. Inputs change 1 time unit after a
// rising edge. Outputs are sampled 1 time unit after the following rising
// edge, which is the one-cycle registered latency.
// -----------------------------------------------------------------------------
module tb_exe_forward_alu;
    logic        clk;
    logic        rst;
    logic [3:0]  EXE_CMD;
    logic [1:0]  val1_sel, val2_sel, ST_val_sel;
    logic [31:0] val1, val2, ALU_res_MEM, result_WB, ST_value_in;
    logic [7:0]  SLLAmount;
    logic [31:0] ALUResult, ST_value_out;

    int n_cmp = 0;
    int n_err = 0;

    exe_forward_alu dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_CMD      (EXE_CMD),
        .val1_sel     (val1_sel),
        .val2_sel     (val2_sel),
        .ST_val_sel   (ST_val_sel),
        .val1         (val1),
        .val2         (val2),
        .ALU_res_MEM  (ALU_res_MEM),
        .result_WB    (result_WB),
        .ST_value_in  (ST_value_in),
        .SLLAmount    (SLLAmount),
        .ALUResult    (ALUResult),
        .ST_value_out (ST_value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an ALU op with all selectors at 00.
    task automatic set_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] amt);
        EXE_CMD    = cmd;
        val1       = a;
        val2       = b;
        SLLAmount  = amt;
        val1_sel   = 2'b00;
        val2_sel   = 2'b00;
        ST_val_sel = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(4'b0000, 32'h1234, 32'h5678, 8'd3);
        ALU_res_MEM = 32'hDEAD; result_WB = 32'hBEEF; ST_value_in = 32'h77;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (ALUResult !== 32'h0) begin
                n_err++;
                $display("FAIL reset_alu[%0d]: got %h expected %h", i, ALUResult, 32'h0);
            end
            n_cmp++;
            if (ST_value_out !== 32'h0) begin
                n_err++;
                $display("FAIL reset_st[%0d]: got %h expected %h", i, ST_value_out, 32'h0);
            end
        end
        rst = 1'b0;
        set_op(4'b0000, 32'd5, 32'd7, 8'd0);
        tick();
        n_cmp++;
        if (ALUResult !== 32'd12) begin
            n_err++;
            $display("FAIL reset_release_add: got %h expected %h", ALUResult, 32'd12);
        end
    endtask

    task automatic test_forwarding();
        set_op(4'b0010, 32'd100, 32'd1, 8'd0);
        ALU_res_MEM = 32'd50; result_WB = 32'd20; ST_value_in = 32'hAB;
        val1_sel = 2'b01; val2_sel = 2'b10; ST_val_sel = 2'b01;
        tick();
        n_cmp++;
        if (ALUResult !== 32'd30) begin
            n_err++;
            $display("FAIL fwd_sub_mem_wb: got %h expected %h", ALUResult, 32'd30);
        end
        n_cmp++;
        if (ST_value_out !== 32'd50) begin
            n_err++;
            $display("FAIL fwd_st_mem: got %h expected %h", ST_value_out, 32'd50);
        end
        val1_sel = 2'b11; val2_sel = 2'b00; ST_val_sel = 2'b10;
        tick();
        n_cmp++;
        if (ALUResult !== 32'd99) begin
            n_err++;
            $display("FAIL fwd_sub_sel11: got %h expected %h", ALUResult, 32'd99);
        end
        n_cmp++;
        if (ST_value_out !== 32'd20) begin
            n_err++;
            $display("FAIL fwd_st_wb: got %h expected %h", ST_value_out, 32'd20);
        end
        ST_val_sel = 2'b00;
        tick();
        n_cmp++;
        if (ST_value_out !== 32'hAB) begin
            n_err++;
            $display("FAIL fwd_st_own: got %h expected %h", ST_value_out, 32'hAB);
        end
        // Every selector picks MEM: A=B=50, so SUB gives 0 and store gives 50.
        val1_sel = 2'b01; val2_sel = 2'b01; ST_val_sel = 2'b01;
        tick();
        n_cmp++;
        if (ALUResult !== 32'd0) begin
            n_err++;
            $display("FAIL fwd_all_mem_alu: got %h expected %h", ALUResult, 32'd0);
        end
        n_cmp++;
        if (ST_value_out !== 32'd50) begin
            n_err++;
            $display("FAIL fwd_all_mem_st: got %h expected %h", ST_value_out, 32'd50);
        end
    endtask

    task automatic test_logic();
        logic [3:0]  cmds [4] = '{4'b0100, 4'b0101, 4'b0111, 4'b0110};
        logic [31:0] exps [4] = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F};
        for (int i = 0; i < 4; i++) begin
            set_op(cmds[i], 32'hF0F0F0F0, 32'hFF00FF00, 8'd0);
            tick();
            n_cmp++;
            if (ALUResult !== exps[i]) begin
                n_err++;
                $display("FAIL logic_cmd%h: got %h expected %h", cmds[i], ALUResult, exps[i]);
            end
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  cmds [6] = '{4'b1000, 4'b1010, 4'b1001, 4'b1001, 4'b1010, 4'b1000};
        logic [7:0]  amts [6] = '{8'd4, 8'd4, 8'd4, 8'd40, 8'd40, 8'd0};
        logic [31:0] exps [6] = '{32'h00000010, 32'h08000000, 32'hF8000000,
                                  32'hFFFFFFFF, 32'h00000000, 32'h80000001};
        for (int i = 0; i < 6; i++) begin
            set_op(cmds[i], 32'h80000001, 32'h0, amts[i]);
            tick();
            n_cmp++;
            if (ALUResult !== exps[i]) begin
                n_err++;
                $display("FAIL shift_cmd%h_by%0d: got %h expected %h",
                         cmds[i], amts[i], ALUResult, exps[i]);
            end
        end
    endtask

    task automatic test_arith();
        logic [3:0]  cmds [6] = '{4'b0000, 4'b0010, 4'b1011, 4'b1011, 4'b1111, 4'b0011};
        logic [31:0] as   [6] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h5, 32'h5};
        logic [31:0] bs   [6] = '{32'h1, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h3, 32'h3};
        logic [31:0] exps [6] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            set_op(cmds[i], as[i], bs[i], 8'd0);
            tick();
            n_cmp++;
            if (ALUResult !== exps[i]) begin
                n_err++;
                $display("FAIL arith%0d_cmd%h: got %h expected %h", i, cmds[i], ALUResult, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_op(4'b0000, 32'd10, 32'd3, 8'd0);
        tick();
        n_cmp++;
        if (ALUResult !== 32'd13) begin
            n_err++;
            $display("FAIL b2b_add: got %h expected %h", ALUResult, 32'd13);
        end
        set_op(4'b0010, 32'd10, 32'd3, 8'd0);
        tick();
        n_cmp++;
        if (ALUResult !== 32'd7) begin
            n_err++;
            $display("FAIL b2b_sub: got %h expected %h", ALUResult, 32'd7);
        end
        set_op(4'b0111, 32'd10, 32'd3, 8'd0);
        tick();
        n_cmp++;
        if (ALUResult !== 32'd9) begin
            n_err++;
            $display("FAIL b2b_xor: got %h expected %h", ALUResult, 32'd9);
        end
    endtask

    task automatic test_mid_reset();
        set_op(4'b0000, 32'd1, 32'd2, 8'd0);
        ST_value_in = 32'h55;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (ALUResult !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_alu: got %h expected %h", ALUResult, 32'd0);
        end
        n_cmp++;
        if (ST_value_out !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_st: got %h expected %h", ST_value_out, 32'd0);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (ALUResult !== 32'd3) begin
            n_err++;
            $display("FAIL midrst_release: got %h expected %h", ALUResult, 32'd3);
        end
        n_cmp++;
        if (ST_value_out !== 32'h55) begin
            n_err++;
            $display("FAIL midrst_release_st: got %h expected %h", ST_value_out, 32'h55);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_op(4'b1111, 32'h0, 32'h0, 8'd0);
        ALU_res_MEM = '0; result_WB = '0; ST_value_in = '0;
        test_reset();
        test_forwarding();
        test_logic();
        test_shifts();
        test_arith();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
